// File: rtl/painterengine_gpu_memcpy2d.sv
// painterengine_gpu_memcpy2d
// Copies a rectangle of height rows x width bytes from a strided source
// surface to a strided destination surface. Each row is cut into DMA blocks
// of at most MAX_BLOCK bytes. Every block runs on the external DMA reader,
// FIFO and DMA writer, and these are held in reset between blocks.
//
// Ports:
//   i_wire_clock / i_wire_reset      : clock, asynchronous active-high reset
//   i_wire_start / i_wire_abort      : job request / abort request
//   i_wire_source_address, i_wire_dest_address, i_wire_width, i_wire_height,
//   i_wire_source_stride, i_wire_dest_stride : job description
//   o_wire_fifo_resetn               : FIFO reset (active low)
//   o_wire_dma_reader_*              : reader reset, block address and length
//   i_wire_dma_reader_done/error     : reader status
//   o_wire_dma_writer_*              : writer reset, block address and length
//   i_wire_dma_writer_done/error     : writer status (done ends the block)
//   o_wire_busy / o_wire_done / o_wire_state : job status
module painterengine_gpu_memcpy2d #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 32,
    parameter int MAX_BLOCK  = 256
) (
    input  logic                  i_wire_clock,
    input  logic                  i_wire_reset,
    input  logic                  i_wire_start,
    input  logic                  i_wire_abort,
    input  logic [ADDR_WIDTH-1:0] i_wire_source_address,
    input  logic [ADDR_WIDTH-1:0] i_wire_dest_address,
    input  logic [LEN_WIDTH-1:0]  i_wire_width,
    input  logic [LEN_WIDTH-1:0]  i_wire_height,
    input  logic [LEN_WIDTH-1:0]  i_wire_source_stride,
    input  logic [LEN_WIDTH-1:0]  i_wire_dest_stride,
    output logic                  o_wire_fifo_resetn,
    output logic                  o_wire_dma_reader_resetn,
    output logic [ADDR_WIDTH-1:0] o_wire_dma_reader_address,
    output logic [LEN_WIDTH-1:0]  o_wire_dma_reader_length,
    input  logic                  i_wire_dma_reader_done,
    input  logic                  i_wire_dma_reader_error,
    output logic                  o_wire_dma_writer_resetn,
    output logic [ADDR_WIDTH-1:0] o_wire_dma_writer_address,
    output logic [LEN_WIDTH-1:0]  o_wire_dma_writer_length,
    input  logic                  i_wire_dma_writer_done,
    input  logic                  i_wire_dma_writer_error,
    output logic                  o_wire_busy,
    output logic                  o_wire_done,
    output logic [31:0]           o_wire_state
);

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_CHECK      = 4'd1;
    localparam logic [3:0] ST_PUSH_PARAM = 4'd2;
    localparam logic [3:0] ST_RUN        = 4'd3;
    localparam logic [3:0] ST_WAIT       = 4'd4;
    localparam logic [3:0] ST_NEXT_ROW   = 4'd5;
    localparam logic [3:0] ST_DONE       = 4'd6;
    localparam logic [3:0] ST_LEN_ERR    = 4'd7;
    localparam logic [3:0] ST_RD_ERR     = 4'd8;
    localparam logic [3:0] ST_WR_ERR     = 4'd9;
    localparam logic [3:0] ST_ABORT      = 4'd10;

    logic [3:0]            state_r;
    logic [3:0]            state_next_s;
    logic [ADDR_WIDTH-1:0] src_base_r;
    logic [ADDR_WIDTH-1:0] dst_base_r;
    logic [LEN_WIDTH-1:0]  width_r;
    logic [LEN_WIDTH-1:0]  height_r;
    logic [LEN_WIDTH-1:0]  src_stride_r;
    logic [LEN_WIDTH-1:0]  dst_stride_r;
    logic [LEN_WIDTH-1:0]  row_r;
    logic [LEN_WIDTH-1:0]  offset_r;
    logic [LEN_WIDTH-1:0]  block_r;
    logic [LEN_WIDTH-1:0]  remaining_s;
    logic [LEN_WIDTH-1:0]  block_s;
    logic                  misaligned_s;
    logic                  resetn_next_s;
    logic                  busy_next_s;
    logic                  done_next_s;
    logic                  unused_reader_done_s;

    // The reader finishing on its own says nothing: the block ends when the
    // writer has drained the FIFO.
    assign unused_reader_done_s = i_wire_dma_reader_done;

    assign remaining_s  = width_r - offset_r;
    assign block_s      = (remaining_s > LEN_WIDTH'(MAX_BLOCK)) ? LEN_WIDTH'(MAX_BLOCK) : remaining_s;
    // Row bases only ever move by aligned strides, so checking the latched
    // bases once in CHECK covers every row.
    assign misaligned_s = |{width_r[1:0], src_base_r[1:0], dst_base_r[1:0],
                            src_stride_r[1:0], dst_stride_r[1:0]};
    assign o_wire_state = {28'd0, state_r};

    // State register plus registered status outputs decoded from the next state.
    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) begin
            state_r                  <= ST_IDLE;
            o_wire_fifo_resetn       <= 1'b0;
            o_wire_dma_reader_resetn <= 1'b0;
            o_wire_dma_writer_resetn <= 1'b0;
            o_wire_busy              <= 1'b0;
            o_wire_done              <= 1'b0;
        end else begin
            state_r                  <= state_next_s;
            o_wire_fifo_resetn       <= resetn_next_s;
            o_wire_dma_reader_resetn <= resetn_next_s;
            o_wire_dma_writer_resetn <= resetn_next_s;
            o_wire_busy              <= busy_next_s;
            o_wire_done              <= done_next_s;
        end
    end

    // Next-state logic; abort in an active state wins over everything else.
    always_comb begin
        state_next_s = state_r;
        if (i_wire_abort && (state_r >= ST_CHECK) && (state_r <= ST_NEXT_ROW)) begin
            state_next_s = ST_ABORT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_wire_start) state_next_s = ST_CHECK;
                    else              state_next_s = ST_IDLE;
                end
                ST_CHECK: begin
                    if (misaligned_s)                                       state_next_s = ST_LEN_ERR;
                    else if ((width_r == '0) || (height_r == '0))           state_next_s = ST_DONE;
                    else                                                    state_next_s = ST_PUSH_PARAM;
                end
                ST_PUSH_PARAM: begin
                    if (remaining_s == '0) state_next_s = ST_NEXT_ROW;
                    else                   state_next_s = ST_RUN;
                end
                ST_RUN: state_next_s = ST_WAIT;
                ST_WAIT: begin
                    if (i_wire_dma_writer_error)      state_next_s = ST_WR_ERR;
                    else if (i_wire_dma_reader_error) state_next_s = ST_RD_ERR;
                    else if (i_wire_dma_writer_done)  state_next_s = ST_PUSH_PARAM;
                    else                              state_next_s = ST_WAIT;
                end
                ST_NEXT_ROW: begin
                    if ((row_r + LEN_WIDTH'(1)) == height_r) state_next_s = ST_DONE;
                    else                                     state_next_s = ST_PUSH_PARAM;
                end
                ST_DONE: state_next_s = ST_IDLE;
                ST_LEN_ERR, ST_RD_ERR, ST_WR_ERR: begin
                    if (i_wire_start) state_next_s = ST_IDLE;
                    else              state_next_s = state_r;
                end
                ST_ABORT: state_next_s = ST_IDLE;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // Output decode of the upcoming state; the DMA runs only while waiting.
    always_comb begin
        resetn_next_s = 1'b0;
        busy_next_s   = 1'b0;
        done_next_s   = 1'b0;
        case (state_next_s)
            ST_CHECK, ST_PUSH_PARAM, ST_RUN, ST_NEXT_ROW, ST_ABORT: busy_next_s = 1'b1;
            ST_WAIT: begin
                busy_next_s   = 1'b1;
                resetn_next_s = 1'b1;
            end
            ST_DONE: done_next_s = 1'b1;
            default: begin
                resetn_next_s = 1'b0;
                busy_next_s   = 1'b0;
                done_next_s   = 1'b0;
            end
        endcase
    end

    // Job registers, row/offset bookkeeping and DMA block parameters.
    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) begin
            src_base_r                <= '0;
            dst_base_r                <= '0;
            width_r                   <= '0;
            height_r                  <= '0;
            src_stride_r              <= '0;
            dst_stride_r              <= '0;
            row_r                     <= '0;
            offset_r                  <= '0;
            block_r                   <= '0;
            o_wire_dma_reader_address <= '0;
            o_wire_dma_writer_address <= '0;
            o_wire_dma_reader_length  <= '0;
            o_wire_dma_writer_length  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (state_next_s == ST_CHECK) begin
                        src_base_r   <= i_wire_source_address;
                        dst_base_r   <= i_wire_dest_address;
                        width_r      <= i_wire_width;
                        height_r     <= i_wire_height;
                        src_stride_r <= i_wire_source_stride;
                        dst_stride_r <= i_wire_dest_stride;
                        row_r        <= '0;
                        offset_r     <= '0;
                    end
                end
                ST_PUSH_PARAM: begin
                    if (state_next_s == ST_RUN) begin
                        block_r                   <= block_s;
                        o_wire_dma_reader_address <= src_base_r + ADDR_WIDTH'(offset_r);
                        o_wire_dma_writer_address <= dst_base_r + ADDR_WIDTH'(offset_r);
                        o_wire_dma_reader_length  <= block_s;
                        o_wire_dma_writer_length  <= block_s;
                    end
                end
                ST_WAIT: begin
                    // Only a clean writer completion advances the offset.
                    if (state_next_s == ST_PUSH_PARAM) offset_r <= offset_r + block_r;
                end
                ST_NEXT_ROW: begin
                    if (state_next_s == ST_PUSH_PARAM) begin
                        row_r      <= row_r + LEN_WIDTH'(1);
                        src_base_r <= src_base_r + ADDR_WIDTH'(src_stride_r);
                        dst_base_r <= dst_base_r + ADDR_WIDTH'(dst_stride_r);
                        offset_r   <= '0;
                    end
                end
                default: begin
                    row_r <= row_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_painterengine_gpu_memcpy2d.sv
module tb_painterengine_gpu_memcpy2d;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] src = 32'd0;
    logic [31:0] dst = 32'd0;
    logic [31:0] width = 32'd0;
    logic [31:0] height = 32'd0;
    logic [31:0] sstride = 32'd0;
    logic [31:0] dstride = 32'd0;
    logic        rdone = 1'b0;
    logic        rerr = 1'b0;
    logic        wdone = 1'b0;
    logic        werr = 1'b0;

    logic        fifo_rn, rd_rn, wr_rn, busy, done;
    logic [31:0] raddr, waddr, rlen, wlen, state;

    logic        fifo_rn2, rd_rn2, wr_rn2, busy2, done2;
    logic [15:0] raddr2, waddr2;
    logic [31:0] rlen2, wlen2, state2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    painterengine_gpu_memcpy2d dut (
        .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_start(start), .i_wire_abort(abort),
        .i_wire_source_address(src), .i_wire_dest_address(dst),
        .i_wire_width(width), .i_wire_height(height),
        .i_wire_source_stride(sstride), .i_wire_dest_stride(dstride),
        .o_wire_fifo_resetn(fifo_rn),
        .o_wire_dma_reader_resetn(rd_rn), .o_wire_dma_reader_address(raddr), .o_wire_dma_reader_length(rlen),
        .i_wire_dma_reader_done(rdone), .i_wire_dma_reader_error(rerr),
        .o_wire_dma_writer_resetn(wr_rn), .o_wire_dma_writer_address(waddr), .o_wire_dma_writer_length(wlen),
        .i_wire_dma_writer_done(wdone), .i_wire_dma_writer_error(werr),
        .o_wire_busy(busy), .o_wire_done(done), .o_wire_state(state)
    );

    painterengine_gpu_memcpy2d #(.ADDR_WIDTH(16), .LEN_WIDTH(32), .MAX_BLOCK(64)) dut2 (
        .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_start(start2), .i_wire_abort(abort),
        .i_wire_source_address(src[15:0]), .i_wire_dest_address(dst[15:0]),
        .i_wire_width(width), .i_wire_height(height),
        .i_wire_source_stride(sstride), .i_wire_dest_stride(dstride),
        .o_wire_fifo_resetn(fifo_rn2),
        .o_wire_dma_reader_resetn(rd_rn2), .o_wire_dma_reader_address(raddr2), .o_wire_dma_reader_length(rlen2),
        .i_wire_dma_reader_done(rdone), .i_wire_dma_reader_error(rerr),
        .o_wire_dma_writer_resetn(wr_rn2), .o_wire_dma_writer_address(waddr2), .o_wire_dma_writer_length(wlen2),
        .i_wire_dma_writer_done(wdone), .i_wire_dma_writer_error(werr),
        .o_wire_busy(busy2), .o_wire_done(done2), .o_wire_state(state2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [31:0] code, input string tag);
        int n = 0;
        while (state !== code && n < 60) begin
            step();
            n++;
        end
        check(tag, 64'(state), 64'(code));
    endtask

    task automatic wait_state2(input logic [31:0] code, input string tag);
        int n = 0;
        while (state2 !== code && n < 60) begin
            step();
            n++;
        end
        check(tag, 64'(state2), 64'(code));
    endtask

    task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] w,
                             input logic [31:0] h, input logic [31:0] ss, input logic [31:0] ds);
        src = s; dst = d; width = w; height = h; sstride = ss; dstride = ds;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // One block: RUN with parameters, WAIT with DMA released, writer_done
    // arriving five cycles after WAIT entry, then back in PUSH_PARAM.
    task automatic do_block(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] len,
                            input string tag);
        wait_state(32'd3, {tag, "_run"});
        check({tag, "_raddr"}, 64'(raddr), 64'(ra));
        check({tag, "_waddr"}, 64'(waddr), 64'(wa));
        check({tag, "_rlen"}, 64'(rlen), 64'(len));
        check({tag, "_wlen"}, 64'(wlen), 64'(len));
        check({tag, "_rn_run"}, 64'({fifo_rn, rd_rn, wr_rn}), 64'(3'b000));
        step();
        check({tag, "_wait"}, 64'(state), 64'd4);
        check({tag, "_rn_wait"}, 64'({fifo_rn, rd_rn, wr_rn}), 64'(3'b111));
        rdone = 1'b1;
        step();
        rdone = 1'b0;
        check({tag, "_rdone_ignored"}, 64'(state), 64'd4);
        repeat (3) step();
        check({tag, "_addr_stable"}, 64'(raddr), 64'(ra));
        wdone = 1'b1;
        step();
        wdone = 1'b0;
        check({tag, "_push"}, 64'(state), 64'd2);
        check({tag, "_rn_push"}, 64'({fifo_rn, rd_rn, wr_rn}), 64'(3'b000));
    endtask

    initial begin
        // Reset values
        repeat (2) step();
        check("rst_state", 64'(state), 64'd0);
        check("rst_rn", 64'({fifo_rn, rd_rn, wr_rn}), 64'(3'b000));
        check("rst_busy_done", 64'({busy, done}), 64'(2'b00));
        check("rst_addr", 64'({raddr, waddr}), 64'd0);
        rst = 1'b0;
        step();
        check("idle_state", 64'(state), 64'd0);

        // Single row, partial last block
        start_job(32'h1000, 32'h8000, 32'd600, 32'd1, 32'd0, 32'd0);
        check("t1_check", 64'(state), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        do_block(32'h1000, 32'h8000, 32'd256, "t1b0");
        do_block(32'h1100, 32'h8100, 32'd256, "t1b1");
        do_block(32'h1200, 32'h8200, 32'd88, "t1b2");
        step();
        check("t1_next_row", 64'(state), 64'd5);
        step();
        check("t1_done_state", 64'(state), 64'd6);
        check("t1_done_pulse", 64'({busy, done}), 64'(2'b01));
        step();
        check("t1_idle", 64'(state), 64'd0);
        check("t1_done_end", 64'(done), 64'd0);

        // 2-D strides
        start_job(32'h1000, 32'h8000, 32'd256, 32'd3, 32'h400, 32'h800);
        do_block(32'h1000, 32'h8000, 32'd256, "t2r0");
        step();
        check("t2_next_row_busy", 64'({state[3:0], busy}), 64'({4'd5, 1'b1}));
        do_block(32'h1400, 32'h8800, 32'd256, "t2r1");
        do_block(32'h1800, 32'h9000, 32'd256, "t2r2");
        step();
        check("t2_last_next_row", 64'({state[3:0], busy}), 64'({4'd5, 1'b1}));
        step();
        check("t2_done", 64'({state[3:0], busy, done}), 64'({4'd6, 1'b0, 1'b1}));
        step();

        // Misaligned width
        start_job(32'h1000, 32'h8000, 32'd6, 32'd1, 32'd0, 32'd0);
        step();
        check("t3_len_err", 64'(state), 64'd7);
        step();
        check("t3_sticky", 64'({state[3:0], fifo_rn, rd_rn, wr_rn, busy}), 64'({4'd7, 4'b0000}));
        start = 1'b1;
        step();
        start = 1'b0;
        check("t3_to_idle", 64'(state), 64'd0);
        step();
        check("t3_no_launch", 64'(state), 64'd0);

        // Zero height: done two cycles after start
        start_job(32'h1000, 32'h8000, 32'd4, 32'd0, 32'd0, 32'd0);
        step();
        check("t4_done", 64'({state[3:0], done, fifo_rn, rd_rn, wr_rn}), 64'({4'd6, 4'b1000}));
        step();
        check("t4_idle", 64'({state[3:0], done}), 64'({4'd0, 1'b0}));

        // Reader error
        start_job(32'h1000, 32'h8000, 32'd8, 32'd1, 32'd0, 32'd0);
        wait_state(32'd4, "t5_wait");
        rerr = 1'b1;
        step();
        rerr = 1'b0;
        check("t5_rd_err", 64'({state[3:0], fifo_rn, rd_rn, wr_rn}), 64'({4'd8, 3'b000}));
        start = 1'b1;
        step();
        start = 1'b0;

        // Writer and reader error together
        start_job(32'h1000, 32'h8000, 32'd8, 32'd1, 32'd0, 32'd0);
        wait_state(32'd4, "t6_wait");
        rerr = 1'b1;
        werr = 1'b1;
        step();
        rerr = 1'b0;
        werr = 1'b0;
        check("t6_wr_err", 64'(state), 64'd9);
        start = 1'b1;
        step();
        start = 1'b0;

        // Writer done with writer error: error wins, offset untouched
        start_job(32'h1000, 32'h8000, 32'd512, 32'd1, 32'd0, 32'd0);
        wait_state(32'd4, "t7_wait");
        wdone = 1'b1;
        werr = 1'b1;
        step();
        wdone = 1'b0;
        werr = 1'b0;
        check("t7_wr_err", 64'(state), 64'd9);
        check("t7_offset", 64'(dut.offset_r), 64'd0);
        start = 1'b1;
        step();
        start = 1'b0;

        // Abort during block 2
        start_job(32'h1000, 32'h8000, 32'd600, 32'd1, 32'd0, 32'd0);
        do_block(32'h1000, 32'h8000, 32'd256, "t8b0");
        wait_state(32'd4, "t8_wait_b1");
        check("t8_b1_addr", 64'(raddr), 64'h1100);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t8_abort", 64'({state[3:0], busy, done, fifo_rn, rd_rn, wr_rn}), 64'({4'd10, 5'b10000}));
        step();
        check("t8_idle", 64'({state[3:0], busy, done}), 64'({4'd0, 2'b00}));
        step();
        check("t8_no_done", 64'(done), 64'd0);

        // Asynchronous reset mid-WAIT
        start_job(32'h1000, 32'h8000, 32'd600, 32'd1, 32'd0, 32'd0);
        wait_state(32'd4, "t9_wait");
        #1;
        rst = 1'b1;
        #1;
        check("t9_state", 64'(state), 64'd0);
        check("t9_rn", 64'({fifo_rn, rd_rn, wr_rn, busy, done}), 64'(5'b00000));
        check("t9_addr", 64'({raddr, waddr}), 64'd0);
        check("t9_len", 64'({rlen, wlen}), 64'd0);
        #1;
        rst = 1'b0;
        step();
        check("t9_after", 64'(state), 64'd0);

        // Parameter sweep: 16-bit addresses, 64-byte blocks, address wrap
        src = 32'h0000_FFC0; dst = 32'h0000_0100; width = 32'd128; height = 32'd1;
        sstride = 32'd0; dstride = 32'd0;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        wait_state2(32'd3, "t10_run0");
        check("t10_raddr0", 64'(raddr2), 64'hFFC0);
        check("t10_len0", 64'(rlen2), 64'd64);
        step();
        wdone = 1'b1;
        step();
        wdone = 1'b0;
        wait_state2(32'd3, "t10_run1");
        check("t10_raddr1_wrap", 64'(raddr2), 64'h0000);
        check("t10_waddr1", 64'(waddr2), 64'h0140);
        step();
        wdone = 1'b1;
        step();
        wdone = 1'b0;
        wait_state2(32'd6, "t10_done_state");
        check("t10_done", 64'(done2), 64'd1);
        check("t10_dut1_idle", 64'(state), 64'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
